cpu_stack_unit: RTL and testbench

Parametrised hardware stack serving the CPU datapath's stack_w_en / stack_r_en / stack_state signals. It generalises the fixed 8-bit, single-purpose stack to configurable width and depth. It adds atomic replace-top (push+pop in one cycle), a combinational peek, an occupancy count, and sticky overflow/underflow error flags. It sits beside the register file and is driven by the control unit; popped data returns to the register write-back mux.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/cpu_stack_ram.sv | 26 ++
 rtl/cpu_stack_unit.sv | 123 ++++++++++++
 tb/tb_cpu_stack_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: stack defaults and the stack operation
// encoding driven by the control unit as {stack_w_en, stack_r_en}.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W      = 8;
  localparam int unsigned CPU_STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    SOP_IDLE = 2'b00,
    SOP_POP  = 2'b01,
    SOP_PUSH = 2'b10,
    SOP_REPL = 2'b11
  } stack_op_e;

endpackage : cpu_pkg

// File: rtl/cpu_stack_ram.sv
// Stack storage: DEPTH x DATA_W array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module cpu_stack_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : cpu_stack_ram

// File: rtl/cpu_stack_unit.sv
// Parametrised CPU hardware stack: push, pop, atomic replace-top, peek,
// occupancy count and sticky overflow/underflow flags.
module cpu_stack_unit
  import cpu_pkg::*;
#(
  parameter  int DATA_W = CPU_DATA_W,
  parameter  int DEPTH  = CPU_STACK_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack_w_en,
  input  logic              stack_r_en,
  input  logic [DATA_W-1:0] w_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  stack_state,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  stack_op_e         op;
  logic [CNT_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     top_idx;
  logic [DATA_W-1:0] top_rd;

  assign op      = stack_op_e'({stack_w_en, stack_r_en});
  assign full    = (sp_q == DEPTH_C);
  assign empty   = (sp_q == '0);
  assign top_idx = AW'(sp_q - ONE_C);

  always_comb begin
    sp_d      = sp_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    // Clear first so a same-cycle set condition below takes priority.
    ovf_d     = ovf_q & ~err_clr;
    unf_d     = unf_q & ~err_clr;
    we        = 1'b0;
    waddr     = AW'(sp_q);
    case (op)
      SOP_PUSH: begin
        if (!full) begin
          we   = 1'b1;
          sp_d = sp_q + ONE_C;
        end else begin
          ovf_d = 1'b1;
        end
      end
      SOP_POP: begin
        if (!empty) begin
          r_data_d  = top_rd;
          r_valid_d = 1'b1;
          sp_d      = sp_q - ONE_C;
        end else begin
          unf_d = 1'b1;
        end
      end
      SOP_REPL: begin
        r_valid_d = 1'b1;
        if (!empty) begin
          r_data_d = top_rd;
          we       = 1'b1;
          waddr    = top_idx;
        end else begin
          r_data_d = w_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q      <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage has no reset, so block writes while reset is held.
  cpu_stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we & ~rst),
    .waddr (waddr),
    .wdata (w_data),
    .raddr (top_idx),
    .rdata (top_rd)
  );

  assign top         = empty ? '0 : top_rd;
  assign stack_state = sp_q;
  assign r_data      = r_data_q;
  assign r_valid     = r_valid_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule : cpu_stack_unit

// File: tb/tb_cpu_stack_unit.sv
// Self-checking bench for cpu_stack_unit: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_cpu_stack_unit;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          stack_w_en, stack_r_en, err_clr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data, top;
  logic          r_valid, full, empty, overflow, underflow;
  logic [CW-1:0] stack_state;

  cpu_stack_unit #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stack_w_en  (stack_w_en),
    .stack_r_en  (stack_r_en),
    .w_data      (w_data),
    .err_clr     (err_clr),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .top         (top),
    .stack_state (stack_state),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        r;
    logic        clr;
    logic [7:0]  d;
    int unsigned st;
    logic [7:0]  tp;
    logic [7:0]  rd;
    logic        rv;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] mdl[$];
  logic [7:0] m_rd;
  logic       m_rv, m_ov, m_un;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic clr, input logic [7:0] d,
                     input int unsigned st, input logic [7:0] tp, input logic [7:0] rd,
                     input logic rv, input logic ov, input logic un);
    vec_t v;
    v.w = w; v.r = r; v.clr = clr; v.d = d; v.st = st;
    v.tp = tp; v.rd = rd; v.rv = rv; v.ov = ov; v.un = un;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    mdl.delete();
    m_rd = '0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
  endtask

  // Reference behaviour: the stack is a queue whose back is the top.
  task automatic model_step(input logic w, input logic r, input logic clr, input logic [7:0] d);
    if (clr) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    m_rv = 1'b0;
    if (w && !r) begin
      if (mdl.size() < DP) mdl.push_back(d);
      else m_ov = 1'b1;
    end else if (!w && r) begin
      if (mdl.size() > 0) begin
        m_rd = mdl.pop_back();
        m_rv = 1'b1;
      end else begin
        m_un = 1'b1;
      end
    end else if (w && r) begin
      m_rv = 1'b1;
      if (mdl.size() > 0) begin
        m_rd = mdl[mdl.size()-1];
        mdl[mdl.size()-1] = d;
      end else begin
        m_rd = d;
      end
    end
  endtask

  task automatic step(input logic w, input logic r, input logic clr, input logic [7:0] d);
    stack_w_en = w; stack_r_en = r; err_clr = clr; w_data = d;
    @(posedge clk);
    #1;
    model_step(w, r, clr, d);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_top;
    exp_top = (mdl.size() > 0) ? mdl[mdl.size()-1] : 8'h00;
    chk({tag, "_state"}, 32'(stack_state), 32'(mdl.size()));
    chk({tag, "_top"}, 32'(top), 32'(exp_top));
    chk({tag, "_full"}, 32'(full), 32'(mdl.size() == DP));
    chk({tag, "_empty"}, 32'(empty), 32'(mdl.size() == 0));
    chk({tag, "_rdata"}, 32'(r_data), 32'(m_rd));
    chk({tag, "_rvalid"}, 32'(r_valid), 32'(m_rv));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, "_unf"}, 32'(underflow), 32'(m_un));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(stack_state), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_top"}, 32'(top), 32'd0);
    chk({tag, "_rvalid"}, 32'(r_valid), 32'd0);
    chk({tag, "_rdata"}, 32'(r_data), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    stack_w_en = 1'b0; stack_r_en = 1'b0; err_clr = 1'b0; w_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    //   w  r  clr d      st tp     rd     rv ov un
    add(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'h11, 1, 8'h11, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'h22, 2, 8'h22, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'h33, 3, 8'h33, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h00, 2, 8'h22, 8'h33, 1, 0, 0);
    add(0, 1, 0, 8'h00, 1, 8'h11, 8'h22, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 8'h00, 8'h11, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 8'h00, 8'h11, 0, 0, 1);
    add(0, 1, 1, 8'h00, 0, 8'h00, 8'h11, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 8'h00, 8'h11, 0, 0, 0);
    add(1, 0, 0, 8'h11, 1, 8'h11, 8'h11, 0, 0, 0);
    add(1, 0, 0, 8'h22, 2, 8'h22, 8'h11, 0, 0, 0);
    add(1, 1, 0, 8'h5A, 2, 8'h5A, 8'h22, 1, 0, 0);
    add(0, 0, 0, 8'h00, 2, 8'h5A, 8'h22, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 8'h11, 8'h5A, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 8'h00, 8'h11, 1, 0, 0);
    add(1, 1, 0, 8'h77, 0, 8'h00, 8'h77, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 8'h77, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(tbl[i].w, tbl[i].r, tbl[i].clr, tbl[i].d);
      chk({t, "_state"}, 32'(stack_state), 32'(tbl[i].st));
      chk({t, "_top"}, 32'(top), 32'(tbl[i].tp));
      chk({t, "_rdata"}, 32'(r_data), 32'(tbl[i].rd));
      chk({t, "_rvalid"}, 32'(r_valid), 32'(tbl[i].rv));
      chk({t, "_ovf"}, 32'(overflow), 32'(tbl[i].ov));
      chk({t, "_unf"}, 32'(underflow), 32'(tbl[i].un));
      chk({t, "_full"}, 32'(full), 32'(tbl[i].st == DP));
      chk({t, "_empty"}, 32'(empty), 32'(tbl[i].st == 0));
    end

    // Fill to DEPTH, overflow, clear, replace-top on full, set-wins-over-clear.
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_state", 32'(stack_state), 32'(DP));
    chk("fill_top", 32'(top), 32'h0F);
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_top", 32'(top), 32'h0F);
    chk("ovf_state", 32'(stack_state), 32'(DP));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h99);
    chk("replfull_ovf", 32'(overflow), 32'd0);
    chk("replfull_rdata", 32'(r_data), 32'h0F);
    chk("replfull_rvalid", 32'(r_valid), 32'd1);
    chk("replfull_top", 32'(top), 32'h99);
    chk("replfull_state", 32'(stack_state), 32'(DP));
    step(1'b1, 1'b0, 1'b1, 8'hBB);
    chk("ovf_setwins", 32'(overflow), 32'd1);
    check_model("full_seq");

    // Drain to 5 entries, then reset asynchronously in the middle of a push.
    for (int i = 0; i < DP - 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_rst_state", 32'(stack_state), 32'd5);
    stack_w_en = 1'b1; stack_r_en = 1'b0; w_data = 8'hC0;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(posedge clk);
    #1;
    chk_reset_vals("arst_hold");
    @(negedge clk);
    rst = 1'b0;
    stack_w_en = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 8'h01);
    chk("post_rst_top", 32'(top), 32'h01);
    chk("post_rst_state", 32'(stack_state), 32'd1);
    check_model("post_rst");

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 800; i++) begin
      int unsigned p;
      logic w, r, c;
      p = $urandom_range(0, 99);
      if (((i / 100) % 2) == 0) begin
        w = (p < 60) || (p >= 90);
        r = (p >= 60);
      end else begin
        w = (p < 15) || (p >= 90);
        r = (p >= 15) && (p < 100) && (p >= 30 || p >= 90);
      end
      c = ($urandom_range(0, 15) == 0);
      step(w, r, c, 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_cpu_stack_unit
